// File: rtl/endgenerate_alu.sv
// rtl/endgenerate_alu.sv - 8-bit registered execute-stage ALU with carry, zero and branch flags
module endgenerate_alu (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic [2:0] instr,
   output logic [7:0] out,
   output logic       co_flag,
   output logic       zero_flag,
   output logic       branch_flag
);

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_SUB = 3'b010,
      OP_AND = 3'b011,
      OP_NOT = 3'b100,
      OP_BEQ = 3'b101,
      OP_OR  = 3'b110,
      OP_XOR = 3'b111
   } op_t;

   logic [8:0] sum;
   logic [8:0] diff;
   logic [7:0] next_out;
   logic       next_co;
   logic       writes_out;

   // Result selection; writes_out marks opcodes that update out, co_flag and zero_flag
   always_comb begin
      sum        = {1'b0, A} + {1'b0, B};
      diff       = {1'b0, A} - {1'b0, B};
      next_out   = out;
      next_co    = co_flag;
      writes_out = 1'b1;
      case (op_t'(instr))
         OP_ADD: begin
            next_out = sum[7:0];
            next_co  = sum[8];
         end
         OP_SUB: begin
            // bit 8 of the zero-extended difference is the borrow (A < B)
            next_out = diff[7:0];
            next_co  = diff[8];
         end
         OP_AND: begin
            next_out = A & B;
            next_co  = 1'b0;
         end
         OP_NOT: begin
            next_out = ~A;
            next_co  = 1'b0;
         end
         OP_OR: begin
            next_out = A | B;
            next_co  = 1'b0;
         end
         OP_XOR: begin
            next_out = A ^ B;
            next_co  = 1'b0;
         end
         default: begin
            // NOP and BEQ leave the result and its flags untouched
            writes_out = 1'b0;
         end
      endcase
   end

   // Output registers; branch_flag is a single-cycle status only set by BEQ
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out         <= 8'h00;
         co_flag     <= 1'b0;
         zero_flag   <= 1'b0;
         branch_flag <= 1'b0;
      end else begin
         branch_flag <= (op_t'(instr) == OP_BEQ) ? (A == B) : 1'b0;
         if (writes_out) begin
            out       <= next_out;
            co_flag   <= next_co;
            zero_flag <= (next_out == 8'h00);
         end
      end
   end

endmodule

// File: tb/tb_endgenerate_alu.sv
// tb/tb_endgenerate_alu.sv - directed scoreboard testbench for endgenerate_alu
module tb_endgenerate_alu;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] A;
   logic [7:0] B;
   logic [2:0] instr;
   logic [7:0] out;
   logic       co_flag;
   logic       zero_flag;
   logic       branch_flag;

   typedef struct {
      logic [7:0] out;
      logic       co;
      logic       zero;
      logic       br;
      string      tag;
   } exp_t;

   exp_t sb[$];

   logic [7:0] m_out;
   logic       m_co;
   logic       m_zero;
   logic       m_br;

   int tests = 0;
   int fails = 0;

   endgenerate_alu dut (
      .CLK         (CLK),
      .RST         (RST),
      .A           (A),
      .B           (B),
      .instr       (instr),
      .out         (out),
      .co_flag     (co_flag),
      .zero_flag   (zero_flag),
      .branch_flag (branch_flag)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out  = 8'h00;
      m_co   = 1'b0;
      m_zero = 1'b0;
      m_br   = 1'b0;
   endtask

   // Drive one operation, push the model's prediction, and compare after the edge
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input string tag);
      logic [8:0] r;
      exp_t       e;
      A     = a;
      B     = b;
      instr = op;
      m_br  = 1'b0;
      r     = {1'b0, m_out};
      case (op)
         3'b001: r = {1'b0, a} + {1'b0, b};
         3'b010: r = {1'b0, a} - {1'b0, b};
         3'b011: r = {1'b0, a & b};
         3'b100: r = {1'b0, ~a};
         3'b110: r = {1'b0, a | b};
         3'b111: r = {1'b0, a ^ b};
         default: ;
      endcase
      if (op == 3'b101) m_br = (a == b);
      if (op != 3'b000 && op != 3'b101) begin
         m_out  = r[7:0];
         m_co   = r[8];
         m_zero = (r[7:0] == 8'h00);
      end
      e.out  = m_out;
      e.co   = m_co;
      e.zero = m_zero;
      e.br   = m_br;
      e.tag  = tag;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      chk({e.tag, "_out"},  out,                e.out);
      chk({e.tag, "_co"},   {7'b0, co_flag},    {7'b0, e.co});
      chk({e.tag, "_zero"}, {7'b0, zero_flag},  {7'b0, e.zero});
      chk({e.tag, "_br"},   {7'b0, branch_flag}, {7'b0, e.br});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out"},  out,                 8'h00);
      chk({tag, "_co"},   {7'b0, co_flag},     8'h00);
      chk({tag, "_zero"}, {7'b0, zero_flag},   8'h00);
      chk({tag, "_br"},   {7'b0, branch_flag}, 8'h00);
   endtask

   initial begin
      RST   = 1'b1;
      A     = 8'h00;
      B     = 8'h00;
      instr = 3'b000;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk_all_zero("reset_init");
      @(negedge CLK);
      RST = 1'b0;

      // Reset asserted between edges mid-sequence
      issue(8'h20, 8'h22, 3'b001, "pre_rst_add");
      issue(8'h05, 8'h05, 3'b101, "pre_rst_beq");
      #2;
      RST = 1'b1;
      #1;
      chk_all_zero("reset_async");
      model_reset();
      A     = 8'hFF;
      B     = 8'h01;
      instr = 3'b001;
      repeat (2) @(posedge CLK);
      #1;
      chk_all_zero("reset_hold");
      @(negedge CLK);
      RST = 1'b0;
      issue(8'h03, 8'h04, 3'b001, "add_3_4");
      chk("add_3_4_const", out, 8'h07);

      // ADD wrap-around
      issue(8'hFF, 8'h01, 3'b001, "add_wrap");
      chk("add_wrap_const", {out[7:0]}, 8'h00);
      chk("add_wrap_co_const", {7'b0, co_flag}, 8'h01);
      chk("add_wrap_zero_const", {7'b0, zero_flag}, 8'h01);
      issue(8'h80, 8'h7F, 3'b001, "add_80_7f");
      chk("add_80_7f_const", out, 8'hFF);

      // SUB equal and borrow
      issue(8'h05, 8'h05, 3'b010, "sub_eq");
      chk("sub_eq_zero_const", {7'b0, zero_flag}, 8'h01);
      issue(8'h02, 8'h03, 3'b010, "sub_borrow");
      chk("sub_borrow_const", out, 8'hFF);
      issue(8'h00, 8'h01, 3'b010, "sub_wrap");
      chk("sub_wrap_co_const", {7'b0, co_flag}, 8'h01);

      // Logic ops, each preceded by a carry-setting ADD
      issue(8'hFF, 8'h02, 3'b001, "pre_and");
      issue(8'hF0, 8'h3C, 3'b011, "and");
      chk("and_const", out, 8'h30);
      issue(8'hFF, 8'h02, 3'b001, "pre_not");
      issue(8'hF0, 8'h3C, 3'b100, "not");
      chk("not_const", out, 8'h0F);
      issue(8'hFF, 8'h02, 3'b001, "pre_or");
      issue(8'hF0, 8'h3C, 3'b110, "or");
      chk("or_const", out, 8'hFC);
      issue(8'hFF, 8'h02, 3'b001, "pre_xor");
      issue(8'hF0, 8'h3C, 3'b111, "xor");
      chk("xor_const", out, 8'hCC);
      chk("xor_co_const", {7'b0, co_flag}, 8'h00);

      // Branch compare
      issue(8'h10, 8'h02, 3'b001, "pre_beq");
      issue(8'h55, 8'h55, 3'b101, "beq_eq");
      chk("beq_eq_br_const", {7'b0, branch_flag}, 8'h01);
      chk("beq_eq_out_const", out, 8'h12);
      issue(8'h01, 8'h02, 3'b101, "beq_ne");
      issue(8'hA5, 8'hA5, 3'b101, "beq_eq2");
      issue(8'h00, 8'h00, 3'b000, "beq_nop");
      chk("beq_nop_br_const", {7'b0, branch_flag}, 8'h00);

      // NOP hold with random operands
      issue(8'h02, 8'h03, 3'b010, "pre_nop");
      for (int i = 0; i < 3; i++) begin
         issue(8'($urandom), 8'($urandom), 3'b000, $sformatf("nop_hold%0d", i));
         chk($sformatf("nop_hold%0d_const", i), out, 8'hFF);
      end

      // Random sweep over all opcodes against the model
      for (int i = 0; i < 40; i++) begin
         issue(8'($urandom), 8'($urandom_range(255, 0)), 3'($urandom_range(7, 0)),
               $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
